// File: rtl/wb_lsu.sv
// Load/store unit at the WB end of the pipe: runs the data-memory req/gnt/rvalid
// handshake, formats store lanes, extracts load data and stalls EX-to-WB meanwhile.
module wb_lsu #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            store_type_i,
  input  logic                  write_en_i,
  input  logic [WORD_WIDTH-1:0] ex_data_i,
  input  logic [WORD_WIDTH-1:0] store_data_i,
  output logic                  stall_ctrl_o,
  output logic                  rf_we_o,
  output logic [WORD_WIDTH-1:0] rf_wdata_o,
  output logic                  misaligned_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [WORD_WIDTH-1:0] data_rdata_i
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  ltype_q, ltype_d;
  logic        we_q, we_d;
  logic        is_load_q, is_load_d;

  logic        is_ld, is_st, mem_op, sz_b, sz_h, sz_w, misal;
  logic [1:0]  off;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [WORD_WIDTH-1:0] ld_data;
  logic        req, stall, rf_we, mis;
  logic [WORD_WIDTH-1:0] rf_wdata;

  // Decode access size; a load wins over a simultaneously encoded store.
  always_comb begin
    is_ld  = (load_type_i >= 3'b001) && (load_type_i <= 3'b101);
    is_st  = (store_type_i != 2'b00);
    mem_op = is_ld || is_st;
    off    = ex_data_i[1:0];
    if (is_ld) begin
      sz_b = (load_type_i == 3'b001) || (load_type_i == 3'b100);
      sz_h = (load_type_i == 3'b010) || (load_type_i == 3'b101);
      sz_w = (load_type_i == 3'b011);
    end else begin
      sz_b = (store_type_i == 2'b01);
      sz_h = (store_type_i == 2'b10);
      sz_w = (store_type_i == 2'b11);
    end
    misal = mem_op && ((sz_h && off[0]) || (sz_w && (off != 2'b00)));
  end

  always_comb begin
    data_be_o = 4'b0000;
    if (sz_b)      data_be_o = 4'b0001 << off;
    else if (sz_h) data_be_o = off[1] ? 4'b1100 : 4'b0011;
    else if (sz_w) data_be_o = 4'b1111;
    case (store_type_i)
      2'b01:   data_wdata_o = {4{store_data_i[7:0]}};
      2'b10:   data_wdata_o = {2{store_data_i[15:0]}};
      default: data_wdata_o = store_data_i;
    endcase
    data_addr_o = {ex_data_i[WORD_WIDTH-1:2], 2'b00};
    data_we_o   = is_st && !is_ld;
  end

  // Extraction uses the offset/type captured at grant, not the live inputs.
  always_comb begin
    byte_v = data_rdata_i[8*off_q +: 8];
    half_v = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (ltype_q)
      3'b001:  ld_data = {{24{byte_v[7]}}, byte_v};
      3'b010:  ld_data = {{16{half_v[15]}}, half_v};
      3'b100:  ld_data = {24'h0, byte_v};
      3'b101:  ld_data = {16'h0, half_v};
      default: ld_data = data_rdata_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    ltype_d   = ltype_q;
    we_d      = we_q;
    is_load_d = is_load_q;
    req       = 1'b0;
    stall     = 1'b0;
    rf_we     = 1'b0;
    mis       = 1'b0;
    rf_wdata  = ex_data_i;
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          rf_we = write_en_i;
        end else if (misal) begin
          mis = 1'b1;
        end else begin
          req   = 1'b1;
          stall = 1'b1;
          state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        req   = 1'b1;
        stall = 1'b1;
        if (data_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        stall    = !data_rvalid_i;
        rf_wdata = ld_data;
        if (data_rvalid_i) begin
          rf_we   = we_q && is_load_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (req && data_gnt_i) begin
      off_d     = off;
      ltype_d   = is_ld ? load_type_i : 3'b000;
      we_d      = write_en_i;
      is_load_d = is_ld;
    end
  end

  // Outputs forced low during reset, even though the input-driven paths are live.
  assign data_req_o   = req   && !rst;
  assign stall_ctrl_o = stall && !rst;
  assign rf_we_o      = rf_we && !rst;
  assign misaligned_o = mis   && !rst;
  assign rf_wdata_o   = rf_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      off_q     <= 2'b00;
      ltype_q   <= 3'b000;
      we_q      <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      ltype_q   <= ltype_d;
      we_q      <= we_d;
      is_load_q <= is_load_d;
    end
  end

endmodule
